// File: rtl/ex_stage_if.sv
// Bundles the ID/EX inputs and EX/MEM outputs of the execute stage.
// slave is the stage itself; master is whoever drives ID/EX and consumes EX/MEM.
interface ex_stage_if;
    logic        VALID_IN;
    logic        FLUSH_IN;
    logic [3:0]  ALUOP_IN;
    logic        ALUSRC_IN;
    logic        REGWRITE_IN;
    logic        MEMTOREG_IN;
    logic        MEMWRITE_IN;
    logic        MEMREAD_IN;
    logic [4:0]  ARD_IN;
    logic [31:0] RS1_IN;
    logic [31:0] RS2_IN;
    logic [31:0] IMMEDIATE_IN;
    logic        STALL_OUT;
    logic        VALID_OUT;
    logic [31:0] ALU_RESULT_OUT;
    logic [31:0] STORE_DATA_OUT;
    logic [4:0]  ARD_OUT;
    logic        REGWRITE_OUT;
    logic        MEMTOREG_OUT;
    logic        MEMWRITE_OUT;
    logic        MEMREAD_OUT;

    modport slave (
        input  VALID_IN, FLUSH_IN, ALUOP_IN, ALUSRC_IN,
        input  REGWRITE_IN, MEMTOREG_IN, MEMWRITE_IN, MEMREAD_IN,
        input  ARD_IN, RS1_IN, RS2_IN, IMMEDIATE_IN,
        output STALL_OUT, VALID_OUT, ALU_RESULT_OUT, STORE_DATA_OUT, ARD_OUT,
        output REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT
    );

    modport master (
        output VALID_IN, FLUSH_IN, ALUOP_IN, ALUSRC_IN,
        output REGWRITE_IN, MEMTOREG_IN, MEMWRITE_IN, MEMREAD_IN,
        output ARD_IN, RS1_IN, RS2_IN, IMMEDIATE_IN,
        input  STALL_OUT, VALID_OUT, ALU_RESULT_OUT, STORE_DATA_OUT, ARD_OUT,
        input  REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU feeding the EX/MEM register.
// Define EX_MUL_EN to add the 32-step shift-add multiplier (opcode 1010) and its stall FSM.
module ex_stage (
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_PASS = 4'b1100;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic        stall;
    logic        mul_done;
    logic [31:0] mul_product;
    logic [31:0] mul_store;
    logic [4:0]  mul_ard;
    logic [3:0]  mul_ctl;

    logic        valid_reg;
    logic [31:0] result_reg;
    logic [31:0] store_reg;
    logic [4:0]  ard_reg;
    logic        regwrite_reg;
    logic        memtoreg_reg;
    logic        memwrite_reg;
    logic        memread_reg;

    assign op_a = bus.RS1_IN;
    assign op_b = bus.ALUSRC_IN ? bus.IMMEDIATE_IN : bus.RS2_IN;

    // MUL deliberately falls into the default: only the FSM path produces a product.
    always_comb begin
        alu_result = 32'd0;
        case (bus.ALUOP_IN)
            OP_ADD:  alu_result = op_a + op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_SLL:  alu_result = op_a << op_b[4:0];
            OP_SRL:  alu_result = op_a >> op_b[4:0];
            OP_SRA:  alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
            OP_SLT:  alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_result = {31'd0, (op_a < op_b)};
            OP_PASS: alu_result = op_b;
            default: alu_result = 32'd0;
        endcase
    end

`ifdef EX_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] mcand_reg;
    logic [31:0] mplier_reg;
    logic [31:0] acc_reg;
    logic [31:0] acc_next;
    logic [31:0] hold_store_reg;
    logic [4:0]  hold_ard_reg;
    logic [3:0]  hold_ctl_reg;
    logic        mul_req;

    assign mul_req  = bus.VALID_IN && (bus.ALUOP_IN == OP_MUL);
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : 32'd0);
    assign stall    = !rst && !bus.FLUSH_IN &&
                      (((state_reg == IDLE) && mul_req) ||
                       ((state_reg == BUSY) && (cnt_reg != 5'd31)));
    // The final step's addition is folded straight into the EX/MEM load.
    assign mul_done    = !bus.FLUSH_IN && (state_reg == BUSY) && (cnt_reg == 5'd31);
    assign mul_product = acc_next;
    assign mul_store   = hold_store_reg;
    assign mul_ard     = hold_ard_reg;
    assign mul_ctl     = hold_ctl_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 5'd0;
            mcand_reg      <= 32'd0;
            mplier_reg     <= 32'd0;
            acc_reg        <= 32'd0;
            hold_store_reg <= 32'd0;
            hold_ard_reg   <= 5'd0;
            hold_ctl_reg   <= 4'd0;
        end else if (bus.FLUSH_IN) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mul_req) begin
                        mcand_reg      <= op_a;
                        mplier_reg     <= op_b;
                        acc_reg        <= 32'd0;
                        cnt_reg        <= 5'd0;
                        hold_store_reg <= bus.RS2_IN;
                        hold_ard_reg   <= bus.ARD_IN;
                        hold_ctl_reg   <= {bus.REGWRITE_IN && (bus.ARD_IN != 5'd0),
                                           bus.MEMTOREG_IN, bus.MEMWRITE_IN, bus.MEMREAD_IN};
                        state_reg      <= BUSY;
                    end
                end
                BUSY: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
`else
    assign stall       = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = 32'd0;
    assign mul_store   = 32'd0;
    assign mul_ard     = 5'd0;
    assign mul_ctl     = 4'd0;
`endif

    // A bubble clears only the qualifying bits; data fields keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg    <= 1'b0;
            result_reg   <= 32'd0;
            store_reg    <= 32'd0;
            ard_reg      <= 5'd0;
            regwrite_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
            memwrite_reg <= 1'b0;
            memread_reg  <= 1'b0;
        end else if (mul_done) begin
            valid_reg    <= 1'b1;
            result_reg   <= mul_product;
            store_reg    <= mul_store;
            ard_reg      <= mul_ard;
            {regwrite_reg, memtoreg_reg, memwrite_reg, memread_reg} <= mul_ctl;
        end else if (bus.FLUSH_IN || stall || !bus.VALID_IN) begin
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
            memwrite_reg <= 1'b0;
            memread_reg  <= 1'b0;
        end else begin
            valid_reg    <= 1'b1;
            result_reg   <= alu_result;
            store_reg    <= bus.RS2_IN;
            ard_reg      <= bus.ARD_IN;
            regwrite_reg <= bus.REGWRITE_IN && (bus.ARD_IN != 5'd0);
            memtoreg_reg <= bus.MEMTOREG_IN;
            memwrite_reg <= bus.MEMWRITE_IN;
            memread_reg  <= bus.MEMREAD_IN;
        end
    end

    assign bus.STALL_OUT      = stall;
    assign bus.VALID_OUT      = valid_reg;
    assign bus.ALU_RESULT_OUT = result_reg;
    assign bus.STORE_DATA_OUT = store_reg;
    assign bus.ARD_OUT        = ard_reg;
    assign bus.REGWRITE_OUT   = regwrite_reg;
    assign bus.MEMTOREG_OUT   = memtoreg_reg;
    assign bus.MEMWRITE_OUT   = memwrite_reg;
    assign bus.MEMREAD_OUT    = memread_reg;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage; expected EX/MEM contents are queued at issue
// and popped when the stage should deliver them. MUL scenarios build only with EX_MUL_EN.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ex_stage_if bus();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] res;
        logic [31:0] store;
        logic [4:0]  ard;
        logic        rw;
        logic        mtr;
        logic        mw;
        logic        mr;
    } ex_t;

    ex_t sb[$];
    int  vectors     = 0;
    int  miscompares = 0;

    function automatic ex_t outs();
        return {bus.VALID_OUT, bus.ALU_RESULT_OUT, bus.STORE_DATA_OUT, bus.ARD_OUT,
                bus.REGWRITE_OUT, bus.MEMTOREG_OUT, bus.MEMWRITE_OUT, bus.MEMREAD_OUT};
    endfunction

    function automatic logic [3:0] bubble_bits();
        return {bus.VALID_OUT, bus.REGWRITE_OUT, bus.MEMWRITE_OUT, bus.MEMREAD_OUT};
    endfunction

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << b[4:0];
            4'd6:  return a >> b[4:0];
            4'd7:  begin ext = {{32{a[31]}}, a} >> b[4:0]; return ext[31:0]; end
            4'd8:  return ((a[31] != b[31]) ? a[31] : (a < b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
`ifdef EX_MUL_EN
            4'd10: return a * b;
`endif
            4'd12: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_inputs(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic alusrc, input logic [4:0] ard,
                              input logic [3:0] ctl);
        bus.VALID_IN     = 1'b1;
        bus.FLUSH_IN     = 1'b0;
        bus.ALUOP_IN     = op;
        bus.RS1_IN       = rs1;
        bus.RS2_IN       = rs2;
        bus.IMMEDIATE_IN = imm;
        bus.ALUSRC_IN    = alusrc;
        bus.ARD_IN       = ard;
        {bus.REGWRITE_IN, bus.MEMTOREG_IN, bus.MEMWRITE_IN, bus.MEMREAD_IN} = ctl;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic alusrc, input logic [4:0] ard,
                         input logic [3:0] ctl, input logic [31:0] res);
        ex_t e;
        set_inputs(op, rs1, rs2, imm, alusrc, ard, ctl);
        e = {1'b1, res, rs2, ard, ctl[3] && (ard != 5'd0), ctl[2], ctl[1], ctl[0]};
        sb.push_back(e);
    endtask

    task automatic go_idle();
        bus.VALID_IN = 1'b0;
        bus.FLUSH_IN = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_inputs(4'b1010, 32'h1234, 32'h5678, 32'h9, 1'b0, 5'd4, 4'b1111);
        @(negedge clk);
        #1;
        vectors++;
        if (bus.STALL_OUT !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall got=%b want=0", bus.STALL_OUT);
        end
        @(negedge clk);
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL reset_outs got=%h want=0", outs());
        end
        $display("reset: outs=%h stall=%b", outs(), bus.STALL_OUT);
        go_idle();
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Fixed vectors with hand-derived results, including the zero-register case.
    task automatic test_spec_vectors();
        issue(4'd0, 32'd5, 32'd0, 32'd7, 1'b1, 5'd3, 4'b1000, 32'd12);
        @(negedge clk);
        issue(4'd7, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd5, 4'b1000, 32'hF800_0000);
        @(negedge clk);
        issue(4'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd6, 4'b1000, 32'd1);
        @(negedge clk);
        issue(4'd0, 32'h100, 32'hDEAD_BEEF, 32'd4, 1'b1, 5'd0, 4'b1010, 32'h104);
        @(negedge clk);
        go_idle();
        // Compare one cycle behind issue: the queue holds four entries by now, check at each step.
        // (Simpler to re-run serially below.)
        sb.delete();
        issue(4'd0, 32'd5, 32'd0, 32'd7, 1'b1, 5'd3, 4'b1000, 32'd12);
        @(negedge clk);
        begin
            ex_t e = sb.pop_front();
            vectors++;
            if (outs() !== e) begin
                miscompares++;
                $display("FAIL spec_add got=%h want=%h", outs(), e);
            end
            $display("txn ADD res=%h ard=%0d rw=%b", bus.ALU_RESULT_OUT, bus.ARD_OUT, bus.REGWRITE_OUT);
        end
        issue(4'd7, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd5, 4'b1000, 32'hF800_0000);
        @(negedge clk);
        begin
            ex_t e = sb.pop_front();
            vectors++;
            if (outs() !== e) begin
                miscompares++;
                $display("FAIL spec_sra got=%h want=%h", outs(), e);
            end
            $display("txn SRA res=%h", bus.ALU_RESULT_OUT);
        end
        issue(4'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd6, 4'b1000, 32'd1);
        @(negedge clk);
        begin
            ex_t e = sb.pop_front();
            vectors++;
            if (outs() !== e) begin
                miscompares++;
                $display("FAIL spec_sltu got=%h want=%h", outs(), e);
            end
            $display("txn SLTU res=%h", bus.ALU_RESULT_OUT);
        end
        issue(4'd0, 32'h100, 32'hDEAD_BEEF, 32'd4, 1'b1, 5'd0, 4'b1010, 32'h104);
        @(negedge clk);
        begin
            ex_t e = sb.pop_front();
            vectors++;
            if (outs() !== e || bus.REGWRITE_OUT !== 1'b0 || bus.STORE_DATA_OUT !== 32'hDEAD_BEEF
                || bus.MEMWRITE_OUT !== 1'b1) begin
                miscompares++;
                $display("FAIL spec_zero_reg got=%h want=%h", outs(), e);
            end
            $display("txn ZERO_REG rw=%b mw=%b store=%h", bus.REGWRITE_OUT, bus.MEMWRITE_OUT, bus.STORE_DATA_OUT);
        end
        go_idle();
        @(negedge clk);
    endtask

    // Every opcode with random operands, each followed by an idle cycle that must bubble.
    task automatic test_alu();
        for (int i = 0; i < 16; i++) begin
            logic [3:0]  op;
            logic [31:0] a, r2, imm, b;
            logic        src;
            op = i[3:0];
`ifdef EX_MUL_EN
            if (op == 4'd10) continue;
`endif
            a   = $urandom;
            r2  = $urandom;
            imm = $urandom;
            src = 1'($urandom_range(0, 1));
            if (i == 5) r2 = 32'd31;
            b = src ? imm : r2;
            issue(op, a, r2, imm, src, 5'($urandom_range(1, 31)), 4'($urandom), model(op, a, b));
            #1;
            vectors++;
            if (bus.STALL_OUT !== 1'b0) begin
                miscompares++;
                $display("FAIL alu_stall op=%h got=%b want=0", op, bus.STALL_OUT);
            end
            @(negedge clk);
            begin
                ex_t e = sb.pop_front();
                vectors++;
                if (outs() !== e) begin
                    miscompares++;
                    $display("FAIL alu op=%h got=%h want=%h", op, outs(), e);
                end
                $display("txn op=%h a=%h b=%h res=%h", op, a, b, bus.ALU_RESULT_OUT);
            end
            go_idle();
            @(negedge clk);
            vectors++;
            if (bubble_bits() !== 4'b0) begin
                miscompares++;
                $display("FAIL idle_bubble got=%b want=0000", bubble_bits());
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [3:0]  op;
            logic [31:0] a, r2;
            op = 4'($urandom_range(0, 9));
            if (op == 4'd10) op = 4'd0;
            a  = $urandom;
            r2 = $urandom;
            issue(op, a, r2, 32'd0, 1'b0, 5'($urandom_range(0, 31)), 4'($urandom), model(op, a, r2));
            @(negedge clk);
            begin
                ex_t e = sb.pop_front();
                vectors++;
                if (outs() !== e) begin
                    miscompares++;
                    $display("FAIL b2b[%0d] got=%h want=%h", i, outs(), e);
                end
                $display("txn b2b op=%h res=%h", op, bus.ALU_RESULT_OUT);
            end
        end
        go_idle();
        @(negedge clk);
    endtask

    // Flush wins over MUL start; the following ADD must still take one cycle.
    task automatic test_flush();
        set_inputs(4'b1010, 32'd3, 32'd4, 32'd0, 1'b0, 5'd9, 4'b1110);
        bus.FLUSH_IN = 1'b1;
        #1;
        vectors++;
        if (bus.STALL_OUT !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_stall got=%b want=0", bus.STALL_OUT);
        end
        @(negedge clk);
        vectors++;
        if (bubble_bits() !== 4'b0) begin
            miscompares++;
            $display("FAIL flush_bubble got=%b want=0000", bubble_bits());
        end
        $display("txn flush valid=%b", bus.VALID_OUT);
        issue(4'd1, 32'd10, 32'd3, 32'd0, 1'b0, 5'd2, 4'b1000, 32'd7);
        @(negedge clk);
        begin
            ex_t e = sb.pop_front();
            vectors++;
            if (outs() !== e) begin
                miscompares++;
                $display("FAIL after_flush got=%h want=%h", outs(), e);
            end
        end
        go_idle();
        @(negedge clk);
    endtask

`ifdef EX_MUL_EN
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
        int stalls = 0;
        issue(4'b1010, a, b, 32'd0, 1'b0, 5'd7, 4'b1000, res);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!bus.STALL_OUT) break;
            stalls++;
            @(negedge clk);
            vectors++;
            if (bus.VALID_OUT !== 1'b0) begin
                miscompares++;
                $display("FAIL mul_bubble cycle=%0d valid=%b want=0", stalls, bus.VALID_OUT);
            end
        end
        vectors++;
        if (stalls != 32) begin
            miscompares++;
            $display("FAIL mul_stall_len got=%0d want=32", stalls);
        end
        @(negedge clk);
        begin
            ex_t e = sb.pop_front();
            vectors++;
            if (outs() !== e) begin
                miscompares++;
                $display("FAIL mul_result got=%h want=%h", outs(), e);
            end
            $display("txn MUL a=%h b=%h res=%h stalls=%0d", a, b, bus.ALU_RESULT_OUT, stalls);
        end
    endtask

    task automatic test_mul();
        run_mul(32'h0001_2345, 32'h0000_0100, 32'h0123_4500);
        go_idle();
        @(negedge clk);
    endtask

    task automatic test_mul_back_to_back();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        run_mul(a, b, a * b);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        go_idle();
        @(negedge clk);
    endtask

    task automatic test_mul_flush();
        logic seen = 1'b0;
        set_inputs(4'b1010, 32'd123, 32'd456, 32'd0, 1'b0, 5'd8, 4'b1000);
        @(negedge clk);
        go_idle();
        repeat (10) @(negedge clk);
        #1;
        vectors++;
        if (bus.STALL_OUT !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_stall got=%b want=1", bus.STALL_OUT);
        end
        bus.FLUSH_IN = 1'b1;
        #1;
        vectors++;
        if (bus.STALL_OUT !== 1'b0) begin
            miscompares++;
            $display("FAIL mulflush_stall got=%b want=0", bus.STALL_OUT);
        end
        @(negedge clk);
        bus.FLUSH_IN = 1'b0;
        #1;
        vectors++;
        if (bus.VALID_OUT !== 1'b0 || bus.STALL_OUT !== 1'b0) begin
            miscompares++;
            $display("FAIL mulflush_after valid=%b stall=%b want 0/0", bus.VALID_OUT, bus.STALL_OUT);
        end
        issue(4'd0, 32'd40, 32'd2, 32'd0, 1'b0, 5'd1, 4'b1000, 32'd42);
        @(negedge clk);
        begin
            ex_t e = sb.pop_front();
            vectors++;
            if (outs() !== e) begin
                miscompares++;
                $display("FAIL mulflush_add got=%h want=%h", outs(), e);
            end
            $display("txn flush-mid-MUL then ADD res=%h", bus.ALU_RESULT_OUT);
        end
        go_idle();
        repeat (30) begin
            @(negedge clk);
            if (bus.VALID_OUT) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL mulflush_ghost got=1 want=0");
        end
    endtask

    task automatic test_reset_mid_mul();
        logic seen = 1'b0;
        set_inputs(4'b1010, 32'd77, 32'd99, 32'd0, 1'b0, 5'd8, 4'b1000);
        repeat (6) @(negedge clk);
        go_idle();
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.STALL_OUT !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmul_stall got=%b want=0", bus.STALL_OUT);
        end
        @(negedge clk);
        vectors++;
        if (outs() !== '0) begin
            miscompares++;
            $display("FAIL rstmul_outs got=%h want=0", outs());
        end
        rst = 1'b0;
        issue(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd4, 4'b1000, 32'd3);
        @(negedge clk);
        begin
            ex_t e = sb.pop_front();
            vectors++;
            if (outs() !== e) begin
                miscompares++;
                $display("FAIL rstmul_add got=%h want=%h", outs(), e);
            end
            $display("txn reset-mid-MUL then ADD res=%h", bus.ALU_RESULT_OUT);
        end
        go_idle();
        repeat (30) begin
            @(negedge clk);
            if (bus.VALID_OUT) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmul_ghost got=1 want=0");
        end
    endtask
`else
    task automatic test_mul_disabled();
        issue(4'b1010, 32'h0001_2345, 32'h100, 32'd0, 1'b0, 5'd7, 4'b1000, 32'd0);
        #1;
        vectors++;
        if (bus.STALL_OUT !== 1'b0) begin
            miscompares++;
            $display("FAIL nomul_stall got=%b want=0", bus.STALL_OUT);
        end
        @(negedge clk);
        begin
            ex_t e = sb.pop_front();
            vectors++;
            if (outs() !== e) begin
                miscompares++;
                $display("FAIL nomul_result got=%h want=%h", outs(), e);
            end
            $display("txn MUL(disabled) res=%h", bus.ALU_RESULT_OUT);
        end
        go_idle();
        @(negedge clk);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        set_inputs(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 4'b0000);
        go_idle();
        @(negedge clk);
        test_reset();
        test_spec_vectors();
        test_alu();
        test_back_to_back();
        test_flush();
`ifdef EX_MUL_EN
        test_mul();
        test_mul_back_to_back();
        test_mul_flush();
        test_reset_mid_mul();
`else
        test_mul_disabled();
`endif
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be, one per line, as name, direction, width, meaning:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- VALID_IN  in  1  ID/EX register holds a real instruction
- FLUSH_IN  in  1  kill the in-flight instruction (branch redirect)
- ALUOP_IN  in  4  operation code
- ALUSRC_IN  in  1  1 = operand B is IMMEDIATE_IN, 0 = operand B is RS2_IN
- REGWRITE_IN, MEMTOREG_IN, MEMWRITE_IN, MEMREAD_IN  in  1 each  control bits passed through to EX/MEM
- ARD_IN  in  5  destination register address
- RS1_IN, RS2_IN, IMMEDIATE_IN  in  32 each  operand A, register B, immediate
- STALL_OUT  out  1  combinational; upstream holds ID/EX contents while high
- VALID_OUT  out  1  EX/MEM slot holds a real instruction
- ALU_RESULT_OUT  out  32  registered result
- STORE_DATA_OUT  out  32  registered copy of RS2_IN
- ARD_OUT  out  5  registered destination register address
- REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT  out  1 each  registered control bits

Function
REQ-003 Operand B SHALL be IMMEDIATE_IN when ALUSRC_IN=1 and RS2_IN otherwise.
REQ-004 The ALUOP_IN encodings SHALL be:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
- 0101 SLL, 0110 SRL, 0111 SRA; shift amount is B[4:0]
- 1000 SLT (signed), 1001 SLTU; result is 0 or 1
- 1010 MUL, low 32 bits of the product
- 1100 PASS B
- all other codes give result 0
REQ-005 All arithmetic SHALL be modulo 2^32 with no overflow flag.
REQ-006 For any non-MUL operation with VALID_IN=1, all EX/MEM outputs SHALL load on the next rising edge, giving a latency of 1.
REQ-007 REGWRITE_OUT SHALL be forced to 0 whenever ARD_IN=0.
REQ-008 The state machine SHALL have two states, IDLE and BUSY, and a 5-bit counter CNT.
REQ-009 In IDLE, VALID_IN=1 with ALUOP_IN=1010 SHALL latch the operands, clear CNT, and move to BUSY.
REQ-010 BUSY SHALL perform one shift-add step per cycle and increment CNT on each step.
REQ-011 When CNT=31 in BUSY, the block SHALL load the product into the EX/MEM outputs with VALID_OUT=1 and return to IDLE.
REQ-012 STALL_OUT SHALL be high when either of these holds:
- IDLE with a valid MUL presented;
- BUSY with CNT not equal to 31.
REQ-013 STALL_OUT SHALL therefore be high for exactly 32 cycles per MUL and low in the completion cycle.
REQ-014 While STALL_OUT=1, the EX/MEM outputs SHALL load a bubble: VALID_OUT and REGWRITE, MEMWRITE and MEMREAD all 0.
REQ-015 When VALID_IN=0, the EX/MEM outputs SHALL load a bubble on the next edge.
REQ-016 FLUSH_IN=1 SHALL load a bubble on the next edge and force the state to IDLE, aborting any MUL in progress.
REQ-017 FLUSH_IN SHALL take priority over MUL completion and over MUL start.
REQ-018 STALL_OUT SHALL be 0 in any cycle where FLUSH_IN=1.
REQ-019 Back-to-back MULs SHALL each take the full stall, because the second is only accepted after the first returns to IDLE.

Reset
REQ-020 rst=1 on a rising edge SHALL clear every registered output to 0, set the state to IDLE and CNT to 0, and drive STALL_OUT to 0 in that cycle.
REQ-021 rst SHALL take priority over FLUSH_IN and over any in-progress MUL.
REQ-022 A reset during BUSY SHALL abort the MUL with no result produced.

Configuration
REQ-023 With macro EX_MUL_EN defined, MUL SHALL behave as in REQ-009 to REQ-013.
REQ-024 Without EX_MUL_EN, the multiplier, state machine and CNT SHALL be absent and STALL_OUT SHALL be tied to 0.
REQ-025 Without EX_MUL_EN, opcode 1010 SHALL give result 0 with latency 1.

Verification
REQ-026 ADD: RS1=5, IMM=7, ALUSRC=1, ARD=3, REGWRITE=1 -> next cycle ALU_RESULT=12, ARD_OUT=3, REGWRITE_OUT=1, VALID_OUT=1.
REQ-027 SRA: RS1=0x80000000, RS2=4, ALUSRC=0 -> ALU_RESULT=0xF8000000; SLTU with RS1=1, RS2=0xFFFFFFFF -> ALU_RESULT=1.
REQ-028 MUL: RS1=0x00012345, RS2=0x00000100 (EX_MUL_EN) -> STALL_OUT high 32 cycles with VALID_OUT=0 throughout, then ALU_RESULT=0x01234500 and VALID_OUT=1.
REQ-029 MUL flush: FLUSH_IN=1 in BUSY with CNT=10 -> next cycle STALL_OUT=0, VALID_OUT=0, state IDLE, no product written.
REQ-030 Reset: rst=1 mid-MUL -> all outputs 0 after the edge; the next ADD completes in 1 cycle.
REQ-031 Zero register: ARD=0, REGWRITE=1 -> REGWRITE_OUT=0; MEMWRITE=1 with STORE data 0xDEADBEEF -> STORE_DATA_OUT=0xDEADBEEF, MEMWRITE_OUT=1.
